path_checker: RTL and testbench
===============================

Name: path_checker

Overview:
- Consumes the 2-bit move stream emitted by the maze-solving rat and replays it from the start cell (0,0).
- Reads the maze memory at every candidate cell and flags a wall hit, an out-of-bounds move, a premature done, or a step-limit overflow.
- Asserts pass when the target cell is reached.
- Sits beside the rat as an independent checker, with its own read port on the maze memory.

Parameters:
CW, 4, coordinate width (grid is 2^CW x 2^CW)
TARGET_X, 15, target column
TARGET_Y, 15, target row
STEP_W, 8, step counter width
MAX_STEPS, 255, maximum accepted moves before failure

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; clears state and begins checking
move_valid  in  1  move is presented
move  in  2  00 up (y-1), 01 right (x+1), 10 left (x-1), 11 down (y+1)
move_ready  out  1  checker accepts a move this cycle
path_done  in  1  producer declares its path complete (pulse)
mem_dout  in  1  maze cell value; 1 = wall, 0 = open (combinational read)
mem_rd  out  1  memory read strobe
x  out  CW  column address to memory, also current position when not reading
y  out  CW  row address to memory, also current position when not reading
step_count  out  STEP_W  accepted legal moves
busy  out  1  checking in progress
pass  out  1  target reached (sticky)
fail  out  1  violation (sticky)
err_code  out  2  00 none, 01 wall, 10 out of bounds, 11 premature done or step overflow

Behaviour:
- Reset (rst=0, async): state IDLE; position (0,0); step_count 0; move_ready, mem_rd, busy, pass, fail 0; err_code 00.
- FSM states: IDLE, WAIT, READ, PASS, FAIL.
- IDLE: outputs hold. start -> WAIT with position, step_count, pass, fail, err_code cleared.
- WAIT: move_ready=1, busy=1.
  - On move_valid&move_ready, compute the candidate from the current position and latch it.
  - Out of bounds: x=0 & left, x=max & right, y=0 & up, y=max & down.
    - Out-of-bounds -> FAIL, err 10; position unchanged.
    - Otherwise -> READ.
  - No wrap-around is ever applied.
- READ (exactly 1 cycle): mem_rd=1, x/y drive the candidate, move_ready=0.
  - mem_dout sampled at the clock edge.
  - Wall (1) -> FAIL, err 01.
  - Open (0): commit the position and increment step_count.
    - Committed position == (TARGET_X,TARGET_Y) -> PASS.
    - Else if step_count reaches MAX_STEPS -> FAIL, err 11.
    - Else -> WAIT.
- Throughput is one move per 2 cycles. Move-to-flag latency is 2 edges after acceptance.
- path_done in WAIT (no move accepted the same cycle) with position != target -> FAIL, err 11.
- path_done in READ is held in a pending flag and evaluated on return to WAIT. If READ ends in PASS, the flag is dropped.
- path_done in IDLE/PASS/FAIL is ignored.
- Simultaneous move_valid and path_done in WAIT: the move is accepted first; path_done is pended as above.
- PASS/FAIL: sticky, move_ready=0, busy=0. pass xor fail.
- start in any state restarts: it behaves as from IDLE and wins over all other events that cycle.
- Async reset mid-READ aborts immediately. mem_rd drops asynchronously.

Optional Feature:
- Macro: PATH_CHECKER_LOOP_DETECT_EN.
- Enabled:
  - Adds a 2^(2*CW)-bit visited map, cleared on start.
  - (0,0) is marked at start. Each commit marks its cell.
  - Committing an already-visited cell raises output loop_seen (1 bit, sticky until start/reset).
  - loop_seen does not cause fail; backtracking is legal.
- Disabled: the loop_seen port and the map are absent.

Decomposition:
- Package maze_pkg:
  - move encodings MV_UP, MV_RIGHT, MV_LEFT, MV_DOWN;
  - error codes ERR_NONE, ERR_WALL, ERR_OOB, ERR_SEQ;
  - the checker state enum.
- Sub-module maze_move_step: combinational; inputs x, y, move; outputs nx, ny, oob. Reusable by the rat.

Test Plan:
- Open 16x16 maze; start; 15 right then 15 down, each move_valid held until ready -> pass=1 after the last READ, step_count=30, err_code=00, fail=0.
- Wall at (1,0); start; move=01 -> mem_rd=1 with x=1,y=0 -> fail=1, err_code=01, position stays (0,0), step_count=0.
- From (0,0), move=00 -> fail=1, err_code=10 one edge after acceptance; mem_rd never asserted.
- 3 legal moves then path_done pulse in WAIT -> fail=1, err_code=11, step_count=3.
- MAX_STEPS=4, open maze, 4 legal non-target moves -> fail=1, err_code=11 after the 4th READ; start pulse mid-run instead -> position (0,0), flags cleared, busy=1.
- With PATH_CHECKER_LOOP_DETECT_EN: right, left -> loop_seen=1 after the second READ, fail=0; rst low mid-READ -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - shared move, error and checker-state encodings for the maze blocks
// Purpose: common typedefs used by path_checker and maze_move_step (and reusable by the rat).
// Contents: move_e (2-bit move encoding), err_e (2-bit error code), chk_state_e (checker FSM).
package maze_pkg;

  typedef enum logic [1:0] {
    MV_UP    = 2'b00,  // y-1
    MV_RIGHT = 2'b01,  // x+1
    MV_LEFT  = 2'b10,  // x-1
    MV_DOWN  = 2'b11   // y+1
  } move_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_WALL = 2'b01,
    ERR_OOB  = 2'b10,
    ERR_SEQ  = 2'b11   // premature done or step overflow
  } err_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_READ,
    ST_PASS,
    ST_FAIL
  } chk_state_e;

endpackage

// File: rtl/path_checker_if.sv
// rtl/path_checker_if.sv - move stream, maze read port and status bundle of path_checker
// Purpose: groups every non-clock/reset signal of path_checker.
// Modports: master = producer/memory/observer side, slave = checker side.
// Config: PATH_CHECKER_LOOP_DETECT_EN adds the loop_seen status signal.
interface path_checker_if #(
  parameter int CW     = 4,
  parameter int STEP_W = 8
);
  logic              start;
  logic              move_valid;
  logic [1:0]        move;
  logic              move_ready;
  logic              path_done;
  logic              mem_dout;
  logic              mem_rd;
  logic [CW-1:0]     x;
  logic [CW-1:0]     y;
  logic [STEP_W-1:0] step_count;
  logic              busy;
  logic              pass;
  logic              fail;
  logic [1:0]        err_code;
`ifdef PATH_CHECKER_LOOP_DETECT_EN
  logic              loop_seen;

  modport master (
    output start, move_valid, move, path_done, mem_dout,
    input  move_ready, mem_rd, x, y, step_count, busy, pass, fail, err_code, loop_seen
  );
  modport slave (
    input  start, move_valid, move, path_done, mem_dout,
    output move_ready, mem_rd, x, y, step_count, busy, pass, fail, err_code, loop_seen
  );
`else
  modport master (
    output start, move_valid, move, path_done, mem_dout,
    input  move_ready, mem_rd, x, y, step_count, busy, pass, fail, err_code
  );
  modport slave (
    input  start, move_valid, move, path_done, mem_dout,
    output move_ready, mem_rd, x, y, step_count, busy, pass, fail, err_code
  );
`endif
endinterface

// File: rtl/maze_move_step.sv
// rtl/maze_move_step.sv - combinational single-move step with bounds check
// Purpose: computes the candidate cell for one move; never wraps around.
// Ports: x_i/y_i current cell, move_i move code, nx_o/ny_o candidate cell,
//        oob_o high when the move would leave the grid (candidate = current then).
module maze_move_step
  import maze_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic [CW-1:0] x_i,
  input  logic [CW-1:0] y_i,
  input  logic [1:0]    move_i,
  output logic [CW-1:0] nx_o,
  output logic [CW-1:0] ny_o,
  output logic          oob_o
);
  localparam logic [CW-1:0] ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] MAXC = {CW{1'b1}};

  always_comb begin
    nx_o  = x_i;
    ny_o  = y_i;
    oob_o = 1'b0;
    case (move_e'(move_i))
      MV_UP:    if (y_i == '0)   oob_o = 1'b1; else ny_o = y_i - ONE;
      MV_RIGHT: if (x_i == MAXC) oob_o = 1'b1; else nx_o = x_i + ONE;
      MV_LEFT:  if (x_i == '0)   oob_o = 1'b1; else nx_o = x_i - ONE;
      MV_DOWN:  if (y_i == MAXC) oob_o = 1'b1; else ny_o = y_i + ONE;
    endcase
  end
endmodule

// File: rtl/path_checker.sv
// rtl/path_checker.sv - replays a rat move stream against the maze and flags violations
// Purpose: walks from (0,0), reads the maze at each candidate cell, reports pass/fail.
// Ports: clk (rising edge), rst (async active-low),
//        bus (path_checker_if.slave): start, move stream, path_done, maze read port
//        (mem_rd/x/y/mem_dout) and status (step_count, busy, pass, fail, err_code).
// Config: PATH_CHECKER_LOOP_DETECT_EN adds a visited map and the sticky loop_seen flag.
module path_checker
  import maze_pkg::*;
#(
  parameter int CW        = 4,
  parameter int TARGET_X  = 15,
  parameter int TARGET_Y  = 15,
  parameter int STEP_W    = 8,
  parameter int MAX_STEPS = 255
) (
  input logic          clk,
  input logic          rst,
  path_checker_if.slave bus
);
  localparam logic [CW-1:0]     TGT_X = CW'(TARGET_X);
  localparam logic [CW-1:0]     TGT_Y = CW'(TARGET_Y);
  localparam logic [STEP_W-1:0] MAX_S = STEP_W'(MAX_STEPS);
  localparam logic [STEP_W-1:0] ONE_S = {{(STEP_W-1){1'b0}}, 1'b1};

  chk_state_e        state_q, state_d;
  logic [CW-1:0]     x_q, x_d, y_q, y_d;     // committed position
  logic [CW-1:0]     cx_q, cx_d, cy_q, cy_d; // candidate under read
  logic [STEP_W-1:0] steps_q, steps_d, steps_inc;
  logic              pass_q, pass_d, fail_q, fail_d;
  logic              pend_q, pend_d;         // path_done seen while a move was in flight
  err_e              err_q, err_d;
  logic [CW-1:0]     nx, ny;
  logic              oob;
  logic              rd_active;

`ifdef PATH_CHECKER_LOOP_DETECT_EN
  localparam int CELLS = 1 << (2 * CW);
  logic [CELLS-1:0] vis_q, vis_d;
  logic             loop_q, loop_d;
`endif

  maze_move_step #(.CW(CW)) u_step (
    .x_i   (x_q),
    .y_i   (y_q),
    .move_i(bus.move),
    .nx_o  (nx),
    .ny_o  (ny),
    .oob_o (oob)
  );

  assign steps_inc = steps_q + ONE_S;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      steps_q <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      pend_q  <= 1'b0;
      err_q   <= ERR_NONE;
`ifdef PATH_CHECKER_LOOP_DETECT_EN
      vis_q   <= '0;
      loop_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      steps_q <= steps_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
`ifdef PATH_CHECKER_LOOP_DETECT_EN
      vis_q   <= vis_d;
      loop_q  <= loop_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    steps_d = steps_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    pend_d  = pend_q;
    err_d   = err_q;
`ifdef PATH_CHECKER_LOOP_DETECT_EN
    vis_d   = vis_q;
    loop_d  = loop_q;
`endif
    if (bus.start) begin
      // start overrides every other event in the same cycle, from any state
      state_d = ST_WAIT;
      x_d     = '0;
      y_d     = '0;
      steps_d = '0;
      pass_d  = 1'b0;
      fail_d  = 1'b0;
      pend_d  = 1'b0;
      err_d   = ERR_NONE;
`ifdef PATH_CHECKER_LOOP_DETECT_EN
      vis_d    = '0;
      vis_d[0] = 1'b1;
      loop_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (bus.move_valid) begin
            // the move goes first; a coincident path_done waits for the result
            pend_d = pend_q | bus.path_done;
            if (oob) begin
              state_d = ST_FAIL;
              fail_d  = 1'b1;
              err_d   = ERR_OOB;
            end else begin
              cx_d    = nx;
              cy_d    = ny;
              state_d = ST_READ;
            end
          end else if (bus.path_done || pend_q) begin
            pend_d = 1'b0;
            if (!(x_q == TGT_X && y_q == TGT_Y)) begin
              state_d = ST_FAIL;
              fail_d  = 1'b1;
              err_d   = ERR_SEQ;
            end
          end
        end
        ST_READ: begin
          pend_d = pend_q | bus.path_done;
          if (bus.mem_dout) begin
            state_d = ST_FAIL;
            fail_d  = 1'b1;
            err_d   = ERR_WALL;
          end else begin
            x_d     = cx_q;
            y_d     = cy_q;
            steps_d = steps_inc;
`ifdef PATH_CHECKER_LOOP_DETECT_EN
            if (vis_q[{cy_q, cx_q}]) loop_d = 1'b1;
            vis_d[{cy_q, cx_q}] = 1'b1;
`endif
            if (cx_q == TGT_X && cy_q == TGT_Y) begin
              state_d = ST_PASS;
              pass_d  = 1'b1;
              pend_d  = 1'b0;
            end else if (steps_inc == MAX_S) begin
              state_d = ST_FAIL;
              fail_d  = 1'b1;
              err_d   = ERR_SEQ;
            end else begin
              state_d = ST_WAIT;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // decoded straight from the state register so reset drops them without a clock
  assign rd_active      = (state_q == ST_READ);
  assign bus.mem_rd     = rd_active;
  assign bus.move_ready = (state_q == ST_WAIT);
  assign bus.busy       = (state_q == ST_WAIT) || rd_active;
  assign bus.x          = rd_active ? cx_q : x_q;
  assign bus.y          = rd_active ? cy_q : y_q;
  assign bus.step_count = steps_q;
  assign bus.pass       = pass_q;
  assign bus.fail       = fail_q;
  assign bus.err_code   = err_q;
`ifdef PATH_CHECKER_LOOP_DETECT_EN
  assign bus.loop_seen  = loop_q;
`endif

endmodule

// File: tb/tb_path_checker.sv
// tb/tb_path_checker.sv - randomized self-checking bench for path_checker
module tb_path_checker;
  import maze_pkg::*;

  localparam int CW = 4;
  localparam int SW = 8;
  localparam int N  = 16;
  localparam int TX = 15;
  localparam int TY = 15;

  logic       clk        = 1'b0;
  logic       rst        = 1'b1;
  logic       start      = 1'b0;
  logic       move_valid = 1'b0;
  logic       path_done  = 1'b0;
  logic [1:0] move       = 2'b00;
  bit         maze [N][N];   // maze[y][x], 1 = wall

  always #5 clk = ~clk;

  path_checker_if #(.CW(CW), .STEP_W(SW)) bus_a ();
  path_checker_if #(.CW(CW), .STEP_W(SW)) bus_b ();

  assign bus_a.start      = start;
  assign bus_a.move_valid = move_valid;
  assign bus_a.move       = move;
  assign bus_a.path_done  = path_done;
  assign bus_a.mem_dout   = maze[bus_a.y][bus_a.x];
  assign bus_b.start      = start;
  assign bus_b.move_valid = move_valid;
  assign bus_b.move       = move;
  assign bus_b.path_done  = path_done;
  assign bus_b.mem_dout   = maze[bus_b.y][bus_b.x];

  path_checker #(.CW(CW), .TARGET_X(TX), .TARGET_Y(TY), .STEP_W(SW), .MAX_STEPS(255)) u_dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave));
  path_checker #(.CW(CW), .TARGET_X(TX), .TARGET_Y(TY), .STEP_W(SW), .MAX_STEPS(4)) u_dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave));

  // reference model: status 0 idle, 1 running, 2 passed, 3 failed
  int m_st[2], m_x[2], m_y[2], m_steps[2], m_err[2], m_max[2];
  bit m_pend[2], m_loop[2];
  bit m_vis[2][N*N];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_x[k] = 0; m_y[k] = 0; m_steps[k] = 0;
      m_err[k] = 0; m_pend[k] = 0; m_loop[k] = 0;
    end
  endtask

  task automatic m_start();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 1; m_x[k] = 0; m_y[k] = 0; m_steps[k] = 0;
      m_err[k] = 0; m_pend[k] = 0; m_loop[k] = 0;
      for (int c = 0; c < N*N; c++) m_vis[k][c] = 1'b0;
      m_vis[k][0] = 1'b1;
    end
  endtask

  task automatic m_fail(input int k, input int e);
    m_st[k] = 3; m_err[k] = e;
  endtask

  task automatic cand(input int x, input int y, input int m, output int nx, output int ny, output bit oob);
    nx = x; ny = y;
    case (m)
      0: ny = y - 1;
      1: nx = x + 1;
      2: nx = x - 1;
      default: ny = y + 1;
    endcase
    oob = (nx < 0) || (nx >= N) || (ny < 0) || (ny >= N);
  endtask

  task automatic m_commit(input int k, input int nx, input int ny);
    if (maze[ny][nx]) begin
      m_fail(k, 1);
    end else begin
      m_x[k] = nx; m_y[k] = ny; m_steps[k]++;
      if (m_vis[k][ny*N + nx]) m_loop[k] = 1'b1;
      m_vis[k][ny*N + nx] = 1'b1;
      if (nx == TX && ny == TY) begin
        m_st[k] = 2; m_pend[k] = 1'b0;
      end else if (m_steps[k] == m_max[k]) begin
        m_fail(k, 3);
      end
    end
  endtask

  task automatic check_dut(input int k);
    string p;
    logic [31:0] ox, oy, osc, ob, op, of, oe, ordy, ord;
    p = (k == 0) ? "a" : "b";
    if (k == 0) begin
      ox = 32'(bus_a.x); oy = 32'(bus_a.y); osc = 32'(bus_a.step_count);
      ob = 32'(bus_a.busy); op = 32'(bus_a.pass); of = 32'(bus_a.fail);
      oe = 32'(bus_a.err_code); ordy = 32'(bus_a.move_ready); ord = 32'(bus_a.mem_rd);
    end else begin
      ox = 32'(bus_b.x); oy = 32'(bus_b.y); osc = 32'(bus_b.step_count);
      ob = 32'(bus_b.busy); op = 32'(bus_b.pass); of = 32'(bus_b.fail);
      oe = 32'(bus_b.err_code); ordy = 32'(bus_b.move_ready); ord = 32'(bus_b.mem_rd);
    end
    chk({p, ".x"}, ox, m_x[k]);
    chk({p, ".y"}, oy, m_y[k]);
    chk({p, ".step_count"}, osc, m_steps[k]);
    chk({p, ".busy"}, ob, 32'(m_st[k] == 1));
    chk({p, ".move_ready"}, ordy, 32'(m_st[k] == 1));
    chk({p, ".mem_rd"}, ord, 32'd0);
    chk({p, ".pass"}, op, 32'(m_st[k] == 2));
    chk({p, ".fail"}, of, 32'(m_st[k] == 3));
    chk({p, ".err_code"}, oe, 32'((m_st[k] == 3) ? m_err[k] : 0));
`ifdef PATH_CHECKER_LOOP_DETECT_EN
    chk({p, ".loop_seen"}, 32'((k == 0) ? bus_a.loop_seen : bus_b.loop_seen), 32'(m_loop[k]));
`endif
  endtask

  task automatic check_read(input int k, input int nx, input int ny);
    string p;
    p = (k == 0) ? "a" : "b";
    chk({p, ".rd.mem_rd"}, 32'((k == 0) ? bus_a.mem_rd : bus_b.mem_rd), 32'd1);
    chk({p, ".rd.x"}, 32'((k == 0) ? bus_a.x : bus_b.x), nx);
    chk({p, ".rd.y"}, 32'((k == 0) ? bus_a.y : bus_b.y), ny);
    chk({p, ".rd.move_ready"}, 32'((k == 0) ? bus_a.move_ready : bus_b.move_ready), 32'd0);
    chk({p, ".rd.busy"}, 32'((k == 0) ? bus_a.busy : bus_b.busy), 32'd1);
  endtask

  // done_mode: 0 none, 1 path_done with the move, 2 path_done during READ
  task automatic do_move(input int m, input int done_mode);
    int nx[2], ny[2];
    bit oob[2], run[2];
    int cnt;
    for (int k = 0; k < 2; k++) begin
      run[k] = (m_st[k] == 1);
      cand(m_x[k], m_y[k], m, nx[k], ny[k], oob[k]);
    end
    @(negedge clk);
    move_valid = 1'b1;
    move       = 2'(m);
    cnt        = 0;
    while (!bus_a.move_ready && cnt < 8) begin
      @(negedge clk);
      cnt++;
    end
    chk("accept_ready", 32'(bus_a.move_ready), 32'd1);
    if (done_mode == 1) path_done = 1'b1;
    @(posedge clk);
    #1;
    move_valid = 1'b0;
    path_done  = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (run[k] && oob[k]) m_fail(k, 2);
      if (run[k] && !oob[k]) begin
        check_read(k, nx[k], ny[k]);
        if (done_mode != 0) m_pend[k] = 1'b1;
      end else begin
        check_dut(k);
      end
    end
    if (done_mode == 2) path_done = 1'b1;
    @(posedge clk);
    #1;
    path_done = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (run[k] && !oob[k]) m_commit(k, nx[k], ny[k]);
      check_dut(k);
    end
    if ((m_pend[0] && m_st[0] == 1) || (m_pend[1] && m_st[1] == 1)) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (m_pend[k] && m_st[k] == 1 && !(m_x[k] == TX && m_y[k] == TY)) m_fail(k, 3);
        m_pend[k] = 1'b0;
        check_dut(k);
      end
    end
  endtask

  task automatic pulse_done();
    @(negedge clk);
    path_done = 1'b1;
    @(posedge clk);
    #1;
    path_done = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (m_st[k] == 1 && !(m_x[k] == TX && m_y[k] == TY)) m_fail(k, 3);
      m_pend[k] = 1'b0;
      check_dut(k);
    end
  endtask

  task automatic do_start(input bit noise);
    @(negedge clk);
    start = 1'b1;
    if (noise) begin
      move_valid = 1'b1;
      move       = 2'($urandom);
      path_done  = 1'($urandom);
    end
    @(posedge clk);
    #1;
    start      = 1'b0;
    move_valid = 1'b0;
    path_done  = 1'b0;
    m_start();
    check_dut(0);
    check_dut(1);
  endtask

  task automatic clear_maze();
    for (int yy = 0; yy < N; yy++)
      for (int xx = 0; xx < N; xx++) maze[yy][xx] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_max[0] = 255;
    m_max[1] = 4;
    m_reset();
    clear_maze();
    #2 rst = 1'b0;
    #2;
    check_dut(0);
    check_dut(1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // moves and path_done in IDLE are ignored
    @(negedge clk);
    move_valid = 1'b1;
    move       = 2'(MV_RIGHT);
    path_done  = 1'b1;
    @(posedge clk);
    #1;
    move_valid = 1'b0;
    path_done  = 1'b0;
    check_dut(0);
    check_dut(1);

    // full open run to the target; b overflows its 4-step limit on the way
    do_start(1'b0);
    for (int i = 0; i < 15; i++) do_move(MV_RIGHT, 0);
    for (int i = 0; i < 15; i++) do_move(MV_DOWN, 0);
    chk("t1.pass", 32'(bus_a.pass), 32'd1);
    chk("t1.steps", 32'(bus_a.step_count), 32'd30);
    chk("t1.b_err", 32'(bus_b.err_code), 32'd3);
    pulse_done();

    // wall at (1,0)
    maze[0][1] = 1'b1;
    do_start(1'b0);
    do_move(MV_RIGHT, 0);
    chk("t2.err", 32'(bus_a.err_code), 32'd1);
    chk("t2.x", 32'(bus_a.x), 32'd0);
    maze[0][1] = 1'b0;

    // out of bounds from the origin
    do_start(1'b0);
    do_move(MV_UP, 0);
    chk("t3.err", 32'(bus_a.err_code), 32'd2);

    // premature done after three moves
    do_start(1'b0);
    do_move(MV_RIGHT, 0);
    do_move(MV_DOWN, 0);
    do_move(MV_RIGHT, 0);
    pulse_done();
    chk("t4.err", 32'(bus_a.err_code), 32'd3);
    chk("t4.steps", 32'(bus_a.step_count), 32'd3);

    // step limit on b, then restart mid-run
    do_start(1'b0);
    do_move(MV_RIGHT, 0);
    do_move(MV_DOWN, 0);
    do_move(MV_RIGHT, 0);
    do_move(MV_DOWN, 0);
    chk("t5.b_fail", 32'(bus_b.fail), 32'd1);
    chk("t5.b_err", 32'(bus_b.err_code), 32'd3);
    do_start(1'b1);
    chk("t5.restart_busy", 32'(bus_a.busy), 32'd1);

    // backtracking is legal
    do_start(1'b0);
    do_move(MV_RIGHT, 0);
    do_move(MV_LEFT, 0);
    chk("t6.fail", 32'(bus_a.fail), 32'd0);
`ifdef PATH_CHECKER_LOOP_DETECT_EN
    chk("t6.loop_seen", 32'(bus_a.loop_seen), 32'd1);
`endif

    // path_done pended from the accept cycle and from READ
    do_start(1'b0);
    do_move(MV_RIGHT, 1);
    chk("t7.err", 32'(bus_a.err_code), 32'd3);
    do_start(1'b0);
    do_move(MV_DOWN, 2);
    chk("t8.err", 32'(bus_a.err_code), 32'd3);

    // pended done dropped when the READ reaches the target
    do_start(1'b0);
    for (int i = 0; i < 15; i++) do_move(MV_RIGHT, 0);
    for (int i = 0; i < 14; i++) do_move(MV_DOWN, 0);
    do_move(MV_DOWN, 1);
    chk("t9.pass", 32'(bus_a.pass), 32'd1);

    // async reset in the middle of READ
    do_start(1'b0);
    @(negedge clk);
    move_valid = 1'b1;
    move       = 2'(MV_RIGHT);
    @(posedge clk);
    #1;
    move_valid = 1'b0;
    chk("t10.rd_before_rst", 32'(bus_a.mem_rd), 32'd1);
    #1 rst = 1'b0;
    #1;
    m_reset();
    check_dut(0);
    check_dut(1);
    @(negedge clk);
    rst = 1'b1;

    // random mazes and move streams
    for (int s = 0; s < 25; s++) begin
      for (int yy = 0; yy < N; yy++)
        for (int xx = 0; xx < N; xx++) maze[yy][xx] = ($urandom % 6 == 0);
      maze[0][0] = 1'b0;
      do_start(1'($urandom));
      for (int i = 0; i < 60 && m_st[0] == 1; i++) begin
        int r;
        r = int'($urandom % 24);
        if (r == 0) pulse_done();
        else if (r == 1) do_start(1'b1);
        else do_move(int'($urandom % 4), ($urandom % 10 == 0) ? 1 + int'($urandom % 2) : 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
